fsm_onehot_monitor: RTL
=======================

Name: fsm_onehot_monitor

Overview:
- Downstream watchdog for a one-hot encoded FSM state register, e.g. a 4-bit one-hot control FSM with reset state 4'b0001.
- Samples the state vector every cycle and flags illegal encodings (zero or multi-hot).
- Detects states held too long (stuck/deadlock), counts transitions and accumulates a visited-state bitmap for reachability coverage.
- Raises an alarm that stays asserted until acknowledged; used for CWE-1245 style detection of unreachable and deadlocked states.

Parameters:
- W, 4, width of the monitored one-hot state vector.
- STUCK_LIMIT, 16, consecutive unchanged cycles that declare a stuck state; range 2..2^CW-1.
- CW, 8, width of the dwell counter.
- IDLE_MASK, 4'b0001, states exempt from stuck detection (legal self-loop idle states).
- EXPECT_MASK, 4'b1111, states that must be visited for coverage_done.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- en  in  1  monitor enable
- clr  in  1  synchronous clear of all sticky status, counters and visited map
- ack  in  1  alarm acknowledge, single-cycle pulse
- state_in  in  W  monitored one-hot state vector
- mon_state  out  2  monitor FSM: 0 IDLE, 1 ARM, 2 MONITOR, 3 ALARM
- alarm  out  1  high while mon_state == ALARM
- alarm_cause  out  2  bit0 illegal encoding, bit1 stuck
- illegal_val  out  W  first illegal vector captured since the last ack/clr
- visited  out  W  OR of all legal states sampled in MONITOR
- coverage_done  out  1  (visited & EXPECT_MASK) == EXPECT_MASK
- dwell_cnt  out  CW  consecutive cycles the current state has been unchanged
- trans_cnt  out  16  count of legal-to-legal state changes, saturating at 16'hFFFF

Behaviour:
- Reset (resetn low, async):
  - mon_state=IDLE; all outputs 0; internal registers state_q and prev_q = 0.
- Input pipeline:
  - state_q <= state_in every cycle; prev_q <= state_q.
  - All checks use state_q and prev_q, so status updates on the second edge after state_in changes (latency 2).
- Legal check: state_q is legal iff exactly one bit is set. 0 and multi-hot values are illegal.
- Monitor FSM:
  - IDLE -> ARM when en=1.
  - ARM (one cycle): loads prev_q from state_q, no checks, no counting. Prevents a false transition count on enable. ARM -> MONITOR.
  - MONITOR: performs all checks.
    - Illegal value, or stuck condition (dwell_cnt reaches STUCK_LIMIT-1 and state unchanged this cycle) -> ALARM.
    - Set the matching alarm_cause bit(s); capture illegal_val if cause bit0 is newly set.
  - ALARM: checks continue. New causes OR into alarm_cause; illegal_val stays held.
    - ack=1 with no new event this cycle -> MONITOR; alarm_cause, illegal_val and dwell_cnt are cleared.
    - ack=1 together with a new event -> remain in ALARM; cause = the new event only.
  - en=0 in any state -> IDLE next cycle; status outputs hold their values.
- visited:
  - In MONITOR/ALARM, visited <= visited | state_q when state_q is legal.
  - Illegal values never touch visited.
- dwell_cnt:
  - Reset to 0 when state_q != prev_q.
  - Reset to 0 when state_q is an IDLE_MASK state.
  - Otherwise increments, saturating at STUCK_LIMIT.
  - Counts only in MONITOR/ALARM.
- trans_cnt: increments when state_q != prev_q, both are legal, and mon_state is MONITOR or ALARM. Saturates at 16'hFFFF.
- clr:
  - Zeroes visited, trans_cnt, dwell_cnt, alarm_cause, illegal_val.
  - Next state = ARM if en=1, otherwise IDLE.
  - clr has priority over ack and over new events in the same cycle.
- Simultaneous illegal and stuck in one cycle: alarm_cause = 2'b11.
- Reset mid-alarm: everything returns to reset values; the alarm is not preserved.

Test Plan:
- Legal walk 0001->0010->0100->0001 with en=1, each state held for 2 cycles -> trans_cnt=3, visited=4'b0111, coverage_done=0 (state 4'b1000 never reached), alarm=0.
- Drive 4'b0110 for one cycle while in MONITOR -> alarm=1 two edges later, alarm_cause=2'b01, illegal_val=4'b0110, visited unchanged; ack pulse -> MONITOR, cause=0.
- Hold 4'b0010 for 20 cycles, STUCK_LIMIT=16 -> alarm_cause=2'b10 on the 16th unchanged cycle, dwell_cnt saturates at 16. Hold 4'b0001 for 40 cycles -> no alarm (IDLE_MASK).
- Drive 4'b0000 on the same cycle as ack while in ALARM -> remain in ALARM, alarm_cause=2'b01, illegal_val=4'b0000.
- Walk through all four states -> coverage_done=1. Pulse clr with en=1 -> visited=0, trans_cnt=0, mon_state ARM then MONITOR, no spurious transition counted.
- Assert resetn low asynchronously mid-ALARM -> all outputs 0 immediately. Toggle en 1->0 in MONITOR -> IDLE with status held.

Source files
------------

// File: rtl/fsm_onehot_monitor.sv
// ---------------------------------------------------------------------------
// fsm_onehot_monitor
//
// Downstream watchdog for a one-hot encoded FSM state register. The monitored
// vector is registered twice (state_q, prev_q) and every check runs on that
// registered pair, so status reacts on the second clock edge after state_in
// changes.
//
// Checks performed while monitoring:
//   - illegal encoding (zero or more than one bit set)
//   - stuck state (same non-idle value held for STUCK_LIMIT cycles)
//   - transition count (legal -> different legal value, saturating)
//   - visited-state bitmap for reachability coverage
// Any illegal or stuck event raises a sticky alarm that holds until ack.
//
// Ports:
//   clk            clock
//   resetn         asynchronous active-low reset
//   en             monitor enable; low sends the monitor FSM to IDLE
//   clr            synchronous clear of status, counters and visited map
//   ack            alarm acknowledge (single-cycle pulse)
//   state_in       monitored one-hot state vector (W bits)
//   mon_state      monitor FSM: 0 IDLE, 1 ARM, 2 MONITOR, 3 ALARM
//   alarm          high while mon_state is ALARM
//   alarm_cause    bit0 illegal encoding, bit1 stuck
//   illegal_val    first illegal vector captured since the last ack/clr
//   visited        OR of all legal states sampled while monitoring
//   coverage_done  every state in EXPECT_MASK has been visited
//   dwell_cnt      consecutive cycles the current state has been unchanged
//   trans_cnt      legal-to-legal state changes, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module fsm_onehot_monitor #(
  parameter int             W           = 4,
  parameter int             STUCK_LIMIT = 16,
  parameter int             CW          = 8,
  parameter logic [W-1:0]   IDLE_MASK   = W'(1),
  parameter logic [W-1:0]   EXPECT_MASK = '1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          clr,
  input  logic          ack,
  input  logic [W-1:0]  state_in,
  output logic [1:0]    mon_state,
  output logic          alarm,
  output logic [1:0]    alarm_cause,
  output logic [W-1:0]  illegal_val,
  output logic [W-1:0]  visited,
  output logic          coverage_done,
  output logic [CW-1:0] dwell_cnt,
  output logic [15:0]   trans_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MONITOR = 2'd2,
    ALARM   = 2'd3
  } mon_state_e;

  localparam logic [CW-1:0] DWELL_MAX    = CW'(STUCK_LIMIT);
  localparam logic [CW-1:0] DWELL_TRIP   = CW'(STUCK_LIMIT - 1);
  localparam logic [15:0]   TRANS_MAX    = 16'hFFFF;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [W-1:0] v);
    return (v != '0) && ((v & (v - W'(1))) == '0);
  endfunction

  function automatic logic [CW-1:0] sat_dwell(input logic [CW-1:0] d);
    return (d >= DWELL_MAX) ? DWELL_MAX : d + CW'(1);
  endfunction

  function automatic logic [15:0] sat_trans(input logic [15:0] t);
    return (t == TRANS_MAX) ? t : t + 16'd1;
  endfunction

  logic [W-1:0]  state_q;
  logic [W-1:0]  prev_q;
  mon_state_e    mon_q;

  mon_state_e    mon_n;
  logic [1:0]    cause_n;
  logic [W-1:0]  ill_n;
  logic [W-1:0]  vis_n;
  logic [CW-1:0] dwell_n;
  logic [15:0]   trans_n;

  logic          cur_legal;
  logic          prev_legal;
  logic          changed;
  logic          idle_hit;
  logic          live;
  logic          ev_illegal;
  logic          ev_stuck;
  logic [1:0]    ev;

  // Event decode on the registered pair
  assign cur_legal  = is_onehot(state_q);
  assign prev_legal = is_onehot(prev_q);
  assign changed    = (state_q != prev_q);
  // Only a legal idle state is exempt; a multi-hot value overlapping the
  // idle mask is still a candidate for stuck detection.
  assign idle_hit   = cur_legal && ((state_q & IDLE_MASK) != '0);
  assign live       = (mon_q == MONITOR) || (mon_q == ALARM);
  assign ev_illegal = live && !cur_legal;
  // Fires once, on the cycle the dwell counter steps to STUCK_LIMIT.
  assign ev_stuck   = live && !changed && !idle_hit && (dwell_cnt == DWELL_TRIP);
  assign ev         = {ev_stuck, ev_illegal};

  always_comb begin
    mon_n   = mon_q;
    cause_n = alarm_cause;
    ill_n   = illegal_val;
    vis_n   = visited;
    dwell_n = dwell_cnt;
    trans_n = trans_cnt;

    if (clr) begin
      cause_n = '0;
      ill_n   = '0;
      vis_n   = '0;
      dwell_n = '0;
      trans_n = '0;
      mon_n   = en ? ARM : IDLE;
    end else if (!en) begin
      // Status is frozen while disabled.
      mon_n = IDLE;
    end else begin
      case (mon_q)
        IDLE:    mon_n = ARM;
        // ARM lets prev_q catch up with state_q so enabling never counts
        // a phantom transition.
        ARM:     mon_n = MONITOR;
        default: begin
          if (cur_legal) begin
            vis_n = visited | state_q;
          end
          if (changed && cur_legal && prev_legal) begin
            trans_n = sat_trans(trans_cnt);
          end
          if (changed || idle_hit) begin
            dwell_n = '0;
          end else begin
            dwell_n = sat_dwell(dwell_cnt);
          end

          if ((mon_q == ALARM) && ack && (ev == 2'b00)) begin
            mon_n   = MONITOR;
            cause_n = '0;
            ill_n   = '0;
            dwell_n = '0;
          end else if ((mon_q == ALARM) && ack) begin
            // Acknowledge collided with a fresh event: report only the new one.
            cause_n = ev;
            ill_n   = ev_illegal ? state_q : '0;
          end else if (ev != 2'b00) begin
            if (ev_illegal && !alarm_cause[0]) begin
              ill_n = state_q;
            end
            cause_n = alarm_cause | ev;
            mon_n   = ALARM;
          end
        end
      endcase
    end
  end

  // Registered stage: input pipeline, monitor FSM and all outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= '0;
      prev_q        <= '0;
      mon_q         <= IDLE;
      alarm         <= 1'b0;
      alarm_cause   <= '0;
      illegal_val   <= '0;
      visited       <= '0;
      coverage_done <= 1'b0;
      dwell_cnt     <= '0;
      trans_cnt     <= '0;
    end else begin
      state_q       <= state_in;
      prev_q        <= state_q;
      mon_q         <= mon_n;
      alarm         <= (mon_n == ALARM);
      alarm_cause   <= cause_n;
      illegal_val   <= ill_n;
      visited       <= vis_n;
      coverage_done <= ((vis_n & EXPECT_MASK) == EXPECT_MASK);
      dwell_cnt     <= dwell_n;
      trans_cnt     <= trans_n;
    end
  end

  assign mon_state = mon_q;

endmodule
